// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch -- instruction fetch unit with a small prefetch buffer.
//
// Fetches 32-bit instruction words over a Wishbone classic master port, with at
// most one bus cycle in flight. Returned words go into a first-word-fall-through
// buffer that the decode stage drains. A branch or exception redirect flushes the
// buffer and restarts fetching at the new target. A bus error is delivered as a
// tagged entry, and fetching then halts until the next redirect.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   branch_i, branch_addr_i        branch/jump redirect and its target
//   exc_i, exc_addr_i              exception/return redirect and its target
//                                  (takes priority over branch_i)
//   instr_valid_o, instr_ready_i   handshake for the buffer head entry
//   instr_o, pc_o, instr_err_o     head entry: word, address, bus-error flag
//   wbm_*                          Wishbone classic master (read-only)
// -----------------------------------------------------------------------------
module if_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        exc_i,
    input  logic [31:0] exc_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_err_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        fetch_pc_reg, fetch_pc_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;

    logic [31:0]        pc_mem    [FIFO_DEPTH];
    logic [31:0]        instr_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] err_mem;

    logic               redirect;
    logic [31:0]        redirect_addr;
    logic               push;
    logic               push_err;
    logic [31:0]        push_data;
    logic               pop;

    // Exceptions win over branches; targets are always word aligned.
    assign redirect      = exc_i | branch_i;
    assign redirect_addr = (exc_i ? exc_addr_i : branch_addr_i) & 32'hFFFF_FFFC;

    assign instr_valid_o = (count_reg != '0);
    assign pop           = instr_valid_o & instr_ready_i;

    // Read-only master: these never change.
    assign wbm_we_o   = 1'b0;
    assign wbm_dat_o  = 32'h0;
    assign wbm_sel_o  = 4'hF;
    assign wbm_addr_o = fetch_pc_reg;
    // cyc/stb decode straight from the state register so that reset drops them
    // the moment rst_ni falls.
    assign wbm_cyc_o  = (state_reg == BUS) || (state_reg == DISCARD);
    assign wbm_stb_o  = wbm_cyc_o;

    // Head is forced to zero when empty so stale entries never show.
    assign instr_o     = instr_valid_o ? instr_mem[rd_ptr_reg] : 32'h0;
    assign pc_o        = instr_valid_o ? pc_mem[rd_ptr_reg]    : 32'h0;
    assign instr_err_o = instr_valid_o ? err_mem[rd_ptr_reg]   : 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_ADDR;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        push          = 1'b0;
        push_err      = 1'b0;
        push_data     = 32'h0;
        case (state_reg)
            IDLE: begin
                // A request may only start while a free slot exists; with one
                // request in flight the buffer can never overflow.
                if (redirect) begin
                    fetch_pc_next = redirect_addr;
                end else if (count_reg < CNT_W'(FIFO_DEPTH)) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                if (redirect) begin
                    // The outstanding response belongs to the old stream: if it
                    // arrives now it is dropped, otherwise wait it out.
                    fetch_pc_next = redirect_addr;
                    state_next    = (wbm_ack_i | wbm_err_i) ? IDLE : DISCARD;
                end else if (wbm_ack_i) begin
                    push          = 1'b1;
                    push_data     = wbm_dat_i;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    state_next    = IDLE;
                end else if (wbm_err_i) begin
                    push       = 1'b1;
                    push_err   = 1'b1;
                    state_next = HALT;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_next = redirect_addr;
                end
                if (wbm_ack_i | wbm_err_i) begin
                    state_next = IDLE;
                end
            end
            HALT: begin
                if (redirect) begin
                    fetch_pc_next = redirect_addr;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (redirect) begin
            // Flush beats any same-cycle push or pop.
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Buffer storage: one register slot per entry.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pc_mem[gi]    <= 32'h0;
                instr_mem[gi] <= 32'h0;
                err_mem[gi]   <= 1'b0;
            end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                pc_mem[gi]    <= fetch_pc_reg;
                instr_mem[gi] <= push_data;
                err_mem[gi]   <= push_err;
            end
        end
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h0, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the prefetch buffer entries; power of two, >= 2.
REQ-003 SHALL have clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_ni, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have branch_i, input, 1, branch/jump redirect request.
REQ-006 SHALL have branch_addr_i, input, 32, branch/jump target.
REQ-007 SHALL have exc_i, input, 1, exception/return redirect request.
REQ-008 SHALL have exc_addr_i, input, 32, exception/return target.
REQ-009 SHALL have instr_valid_o, output, 1, buffer head holds a valid entry.
REQ-010 SHALL have instr_ready_i, input, 1, decode accepts the head entry.
REQ-011 SHALL have instr_o, output, 32, head instruction word.
REQ-012 SHALL have pc_o, output, 32, head instruction address.
REQ-013 SHALL have instr_err_o, output, 1, head entry ended in a bus error.
REQ-014 SHALL have Wishbone master wbm_dat_i (in, 32), wbm_ack_i (in, 1), wbm_err_i (in, 1), wbm_addr_o (out, 32), wbm_dat_o (out, 32), wbm_sel_o (out, 4), wbm_cyc_o (out, 1), wbm_stb_o (out, 1), wbm_we_o (out, 1).

Function
REQ-015 SHALL hold wbm_we_o=0, wbm_dat_o=0, wbm_sel_o=4'hF constantly.
REQ-016 SHALL run FSM states IDLE, BUS, DISCARD, HALT, with one outstanding Wishbone classic cycle at most.
REQ-017 SHALL keep a 32-bit fetch_pc; wbm_addr_o = fetch_pc; wbm_cyc_o = wbm_stb_o = 1 exactly in BUS and DISCARD.
REQ-018 IDLE -> BUS when count < FIFO_DEPTH and no redirect this cycle; else stay IDLE.
REQ-019 BUS on wbm_ack_i without redirect: push {fetch_pc, wbm_dat_i, err=0}, fetch_pc += 4 (mod 2^32 wrap), -> IDLE.
REQ-020 BUS on wbm_err_i without redirect: push {fetch_pc, 32'h0, err=1}, fetch_pc unchanged, -> HALT; no further fetch until a redirect.
REQ-021 Redirect = exc_i | branch_i; exc_i takes priority; target low two bits forced to 0.
REQ-022 Redirect in any state: flush buffer (count=0, pointers reset), fetch_pc <= target; flush overrides same-cycle push and pop.
REQ-023 Redirect in BUS with no ack/err that cycle -> DISCARD; with ack/err that cycle, the response is dropped -> IDLE.
REQ-024 DISCARD: hold cyc/stb until ack or err, drop the response, -> IDLE; a further redirect updates fetch_pc only.
REQ-025 Redirect in IDLE or HALT -> IDLE; the new fetch issues on the following cycle.
REQ-026 Buffer SHALL be first-word-fall-through FIFO; instr_valid_o = (count != 0); instr_o/pc_o/instr_err_o show head entry.
REQ-027 Pop occurs when instr_valid_o & instr_ready_i; same-cycle push and pop keeps count unchanged.
REQ-028 Overflow SHALL be impossible: issue requires count < FIFO_DEPTH with one request in flight; count width clog2(FIFO_DEPTH)+1.
REQ-029 Latency: zero-wait slave, IDLE->BUS at edge n, ack in cycle n, entry valid from cycle n+1; sustained rate one word per two cycles.
REQ-030 instr_ready_i while instr_valid_o=0 SHALL have no effect.

Reset
REQ-031 While rst_ni=0: state IDLE, fetch_pc=RESET_ADDR, count=0, wbm_cyc_o=wbm_stb_o=0, instr_valid_o=0, instr_o=0, pc_o=0, instr_err_o=0.
REQ-032 Reset assertion mid-bus-cycle SHALL drop cyc/stb immediately; any later ack SHALL be ignored.
REQ-033 First request SHALL issue on the first rising edge after rst_ni deasserts.

Verification
REQ-034 Reset release, zero-wait slave returns addr-based data, ready=1 -> pc_o sequence 0x0,0x4,0x8 with matching instr_o, no gaps beyond REQ-029.
REQ-035 ready=0, FIFO_DEPTH=4 -> exactly 4 fetches then cyc stays 0; ready=1 -> drain 0x0..0xC in order, fetching resumes.
REQ-036 branch_i=1, branch_addr_i=0x103 while slave stalls ack 3 cycles -> stale ack dropped, buffer empty, next fetch at 0x100.
REQ-037 exc_i and branch_i same cycle, addrs 0x200/0x300 -> next fetch 0x200.
REQ-038 wbm_err_i on fetch at 0x8 -> entry pc 0x8, instr_err_o=1, FSM HALT, no cyc until redirect to 0x40 resumes at 0x40.
REQ-039 rst_ni low for one cycle mid-BUS -> outputs at REQ-031 values asynchronously, refetch from RESET_ADDR.
